sipo_deser: RTL and testbench
=============================

SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter: N, 4, word width in bits; legal range N >= 2.
REQ-002 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: sin  input  1  serial data bit.
REQ-005 SHALL have port: sin_valid  input  1  sin carries a bit this cycle.
REQ-006 SHALL have port: frame  input  1  qualified by sin_valid; marks first bit of a word.
REQ-007 SHALL have port: msb_first  input  1  bit order; 1 = first bit is MSB, 0 = first bit is LSB.
REQ-008 SHALL have port: clr_err  input  1  clears sticky error flags.
REQ-009 SHALL have port: dout  output  N  assembled parallel word.
REQ-010 SHALL have port: dout_valid  output  1  dout holds an unconsumed word.
REQ-011 SHALL have port: dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
REQ-012 SHALL have port: overrun  output  1  sticky; a completed word was dropped.
REQ-013 SHALL have port: frame_err  output  1  sticky; a partial word was abandoned.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT.
REQ-015 IDLE: sin_valid && !frame SHALL be ignored.
REQ-016 IDLE: sin_valid && frame SHALL load bit 0, set bit count to 1, latch msb_first, and go to SHIFT.
REQ-017 SHALL keep an internal shift register separate from the dout register, so reception continues while dout waits.
REQ-018 SHIFT, latched msb_first=1: each accepted bit SHALL shift the register left with sin entering at bit 0.
REQ-019 SHIFT, latched msb_first=0: each accepted bit SHALL shift the register right with sin entering at bit N-1.
REQ-020 Cycles with sin_valid=0 SHALL leave the shift register, bit count and state unchanged.
REQ-021 When the Nth bit is accepted, the complete word SHALL transfer to dout and dout_valid SHALL be 1 on the following cycle.
REQ-022 After the Nth bit is accepted, the FSM SHALL return to IDLE; a frame bit in the very next cycle SHALL start a new word with no gap.
REQ-023 A word that completes while dout_valid=1 and dout_ready=1 in the same cycle SHALL replace dout, and dout_valid SHALL stay 1 (no bubble).
REQ-024 A word that completes while dout_valid=1 and dout_ready=0 SHALL be dropped, dout SHALL keep the old word, and overrun SHALL be set to 1.
REQ-025 dout_valid SHALL clear on dout_valid && dout_ready when no word completes in that cycle.
REQ-026 dout and dout_valid SHALL stay stable while dout_valid=1 and dout_ready=0.
REQ-027 SHIFT with sin_valid && frame before N bits: partial word discarded, frame_err set to 1, new word started as in REQ-016.
REQ-028 clr_err=1 SHALL clear overrun and frame_err, except that a set event in the same cycle wins.
REQ-029 The bit counter SHALL be $clog2(N+1) bits wide and SHALL never exceed N.

Reset
REQ-030 rst SHALL force: state IDLE, bit count 0, shift register 0, dout 0, dout_valid 0, overrun 0, frame_err 0.
REQ-031 rst mid-word SHALL discard the partial word and SHALL NOT set frame_err.
REQ-032 rst SHALL override all other inputs in the same cycle.

Structure
REQ-033 Package sipo_pkg SHALL hold the state enum (IDLE, SHIFT) and the default width constant.
REQ-034 No sub-module is needed; the shift datapath, counter and FSM SHALL sit in one module.
REQ-035 All registered logic SHALL use a single always_ff on clk.

Verification
REQ-036 N=4, msb_first=1, bits 1,0,1,1 (frame on first), dout_ready=1 -> dout=4'hB, dout_valid=1 for exactly one cycle, one cycle after bit 4.
REQ-037 N=4, msb_first=0, bits 1,0,1,1 -> dout=4'hD; same bits with sin_valid gaps of 0-3 cycles -> identical result.
REQ-038 dout_ready=0, words 4'hA then 4'h5 back-to-back -> dout stays 4'hA, overrun=1; then one clr_err pulse -> overrun=0.
REQ-039 Frame re-asserted after 2 bits, then 1,1,0,0 msb_first=1 -> frame_err=1, dout=4'hC, no word emitted for the partial.
REQ-040 rst asserted after 3 bits of a word -> all outputs 0, frame_err=0; the next framed word decodes correctly.
REQ-041 Random sin, frame, msb_first and dout_ready for 1000 cycles, checked against a bit-accurate reference model -> no mismatches.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
package sipo_pkg;

  localparam int SIPO_N_DEFAULT = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_deser.sv
// Framed serial-in/parallel-out deserializer with a one-word output register,
// selectable bit order and sticky overrun / framing-error flags.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int N = SIPO_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         frame,
  input  logic         msb_first,
  input  logic         clr_err,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overrun,
  output logic         frame_err,
  output state_t       state_dbg
);

  localparam int CW = $clog2(N + 1);

  // Output handshake: a word transfers on a cycle where dout_valid && dout_ready;
  // while dout_valid is high and dout_ready low, dout and dout_valid hold steady.

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   sh, sh_nxt;
  logic           msb_l, msb_l_nxt;
  logic [N-1:0]   dout_nxt;
  logic           dout_valid_nxt;
  logic           overrun_nxt, frame_err_nxt;
  logic           done, set_ov, set_fe;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      msb_l      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      sh         <= sh_nxt;
      msb_l      <= msb_l_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      overrun    <= overrun_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    sh_nxt         = sh;
    msb_l_nxt      = msb_l;
    dout_nxt       = dout;
    dout_valid_nxt = dout_valid;
    done           = 1'b0;
    set_ov         = 1'b0;
    set_fe         = 1'b0;

    if (dout_valid && dout_ready) begin
      dout_valid_nxt = 1'b0;
    end

    if (sin_valid) begin
      if (frame) begin
        // The first bit lands where a shift of an all-zero register would put it,
        // so after N-1 further shifts it ends up at the MSB or LSB as required.
        set_fe    = (state == SHIFT);
        sh_nxt    = msb_first ? {{(N-1){1'b0}}, sin} : {sin, {(N-1){1'b0}}};
        cnt_nxt   = CW'(1);
        msb_l_nxt = msb_first;
        state_nxt = SHIFT;
      end else if (state == SHIFT) begin
        sh_nxt = msb_l ? {sh[N-2:0], sin} : {sin, sh[N-1:1]};
        if (cnt == CW'(N - 1)) begin
          done      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
    end

    if (done) begin
      if (!dout_valid || dout_ready) begin
        dout_nxt       = sh_nxt;
        dout_valid_nxt = 1'b1;
      end else begin
        set_ov = 1'b1;
      end
    end

    overrun_nxt   = set_ov | (overrun & ~clr_err);
    frame_err_nxt = set_fe | (frame_err & ~clr_err);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: directed scenarios plus a random run
// compared cycle by cycle against a bit-list reference model and a word scoreboard.
module tb_sipo_deser;
  import sipo_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, sin, sin_valid, frame, msb_first, clr_err, dout_ready;
  logic [N-1:0] dout;
  logic         dout_valid, overrun, frame_err;
  state_t       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] exp_q[$];

  // Reference model: collects received bits in order, assembles on completion.
  bit           m_busy;
  int           m_cnt;
  bit           m_msb;
  bit           m_bits[N];
  logic [N-1:0] m_dout;
  bit           m_valid, m_ov, m_fe;

  sipo_deser #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .frame     (frame),
    .msb_first (msb_first),
    .clr_err   (clr_err),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun   (overrun),
    .frame_err (frame_err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] assemble();
    logic [N-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (m_msb) w[N-1-i] = m_bits[i];
      else       w[i]     = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_update(input bit r, s, v, f, m, rd, c);
    bit done, set_ov, set_fe;
    done = 0; set_ov = 0; set_fe = 0;
    if (r) begin
      m_busy = 0; m_cnt = 0; m_msb = 0; m_dout = '0;
      m_valid = 0; m_ov = 0; m_fe = 0;
      exp_q.delete();
      return;
    end
    if (v) begin
      if (f) begin
        if (m_busy) set_fe = 1;
        m_busy = 1; m_cnt = 1; m_msb = m; m_bits[0] = s;
      end else if (m_busy) begin
        m_bits[m_cnt] = s;
        m_cnt++;
        if (m_cnt == N) begin
          done = 1; m_busy = 0; m_cnt = 0;
        end
      end
    end
    if (done) begin
      if (!m_valid || rd) begin
        m_dout  = assemble();
        m_valid = 1;
        exp_q.push_back(m_dout);
      end else begin
        set_ov = 1;
      end
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
    m_ov = set_ov | (m_ov & !c);
    m_fe = set_fe | (m_fe & !c);
  endtask

  // Called at a negedge: drive, consume any handshake, advance model, check after the edge.
  task automatic step(input bit r, s, v, f, m, rd, c);
    rst = r; sin = s; sin_valid = v; frame = f; msb_first = m; dout_ready = rd; clr_err = c;
    if (!r && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) check("unexpected_word", 32'd1, 32'd0);
      else                   check("sb_word", 32'(dout), 32'(exp_q.pop_front()));
    end
    model_update(r, s, v, f, m, rd, c);
    @(posedge clk);
    #1;
    check("dout_valid", 32'(dout_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ov));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    if (m_valid || r) check("dout", 32'(dout), 32'(m_dout));
    @(negedge clk);
  endtask

  task automatic idle(input bit rd, input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, rd, 0);
  endtask

  // Bits are sent b[N-1] first; gaps of 0..maxgap idle cycles precede each bit.
  task automatic send_word(input logic [N-1:0] b, input bit m, rd, input int maxgap);
    for (int i = 0; i < N; i++) begin
      idle(rd, $urandom_range(0, maxgap));
      step(0, b[N-1-i], 1, (i == 0), m, rd, 0);
    end
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 1);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // MSB first, single-cycle valid pulse with a ready consumer
    idle(1, 2);
    send_word(4'b1011, 1, 1, 0);
    check("msb_dout", 32'(dout), 32'hB);
    check("msb_valid", 32'(dout_valid), 32'd1);
    idle(1, 1);
    check("msb_valid_drop", 32'(dout_valid), 32'd0);

    // LSB first, back-to-back and with gaps
    send_word(4'b1011, 0, 1, 0);
    check("lsb_dout", 32'(dout), 32'hD);
    idle(1, 1);
    send_word(4'b1011, 0, 1, 3);
    check("lsb_gap_dout", 32'(dout), 32'hD);
    check("lsb_gap_valid", 32'(dout_valid), 32'd1);
    idle(1, 1);

    // Overrun: consumer stalled across two words
    send_word(4'b1010, 1, 0, 0);
    send_word(4'b0101, 1, 0, 0);
    check("ovr_dout", 32'(dout), 32'hA);
    check("ovr_flag", 32'(overrun), 32'd1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("ovr_clear", 32'(overrun), 32'd0);
    check("ovr_hold", 32'(dout), 32'hA);
    idle(1, 2);

    // Framing error: partial word abandoned by a new frame
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 1, 1, 1, 1, 1, 0);
    check("fe_flag", 32'(frame_err), 32'd1);
    check("fe_no_word", 32'(dout_valid), 32'd0);
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    check("fe_dout", 32'(dout), 32'hC);
    step(0, 0, 0, 0, 0, 1, 1);
    check("fe_clear", 32'(frame_err), 32'd0);

    // Reset mid-word, then a clean word
    step(0, 1, 1, 1, 1, 1, 0);
    step(0, 1, 1, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    step(1, 1, 1, 0, 1, 1, 0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_valid", 32'(dout_valid), 32'd0);
    check("mid_rst_fe", 32'(frame_err), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    send_word(4'b1011, 1, 1, 1);
    check("post_rst_dout", 32'(dout), 32'hB);

    // Random traffic against the model
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
